// File: rtl/pipo_write_arbiter_if.sv
// Write bus between the requesting datapath units and the arbiter.
// Requests arrive as packed per-requester slices; grant/PIPO drive return registered.
interface pipo_write_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 4,
  parameter int NREG  = 4,
  parameter int AW    = 2
);
  logic [NREQ-1:0]       req;
  logic [NREQ-1:0]       req_lock;
  logic [NREQ*AW-1:0]    req_addr;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       gnt;
  logic [NREG-1:0]       reg_en;
  logic [WIDTH-1:0]      reg_d;
  logic                  busy;

  modport master (
    output req, req_lock, req_addr, req_data,
    input  gnt, reg_en, reg_d, busy
  );

  modport slave (
    input  req, req_lock, req_addr, req_data,
    output gnt, reg_en, reg_d, busy
  );
endinterface

// File: rtl/pipo_write_arbiter.sv
// Round-robin write arbiter for a shared PIPO bank; one registered write per grant, 1-cycle latency.
// No backpressure: a requester holds req until it sees gnt, then advances or drops it.
module pipo_write_arbiter #(
  parameter int NREQ     = 4,
  parameter int WIDTH    = 4,
  parameter int NREG     = 4,
  parameter int AW       = 2,
  parameter int MAX_HOLD = 3
) (
  input logic                clk,
  input logic                rst,
  pipo_write_arbiter_if.slave bus
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int HW = $clog2(MAX_HOLD + 1);

  typedef enum logic [1:0] {IDLE, GRANT, LOCK} state_t;

  state_t           state;
  logic [PW-1:0]    rr_ptr;
  logic [PW-1:0]    owner;
  logic [HW-1:0]    hold_cnt;
  logic [NREQ-1:0]  gnt_q;
  logic [NREG-1:0]  reg_en_q;
  logic [WIDTH-1:0] reg_d_q;

  logic [AW-1:0]    addr_a [NREQ];
  logic [WIDTH-1:0] data_a [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign addr_a[i] = bus.req_addr[i*AW +: AW];
    assign data_a[i] = bus.req_data[i*WIDTH +: WIDTH];
  end

  // Addresses past the end of the bank decode to no enable, so the write is dropped.
  function automatic logic [NREG-1:0] decode(input logic [AW-1:0] a);
    logic [NREG-1:0] en;
    en = '0;
    for (int r = 0; r < NREG; r++) begin
      if (a == AW'(r)) en[r] = 1'b1;
    end
    return en;
  endfunction

  logic [NREQ-1:0] owner_bit;
  logic [NREQ-1:0] others;
  logic [NREQ-1:0] cand;
  logic [NREQ-1:0] win_bit;
  logic            hold_hit;
  logic            keep;
  logic            found;
  logic [PW-1:0]   win;
  int              idx;

  always_comb begin
    owner_bit        = '0;
    owner_bit[owner] = 1'b1;
    others           = bus.req & ~owner_bit;
    hold_hit         = (hold_cnt >= HW'(MAX_HOLD));
    keep             = (state == LOCK) && bus.req[owner] && bus.req_lock[owner] &&
                       (!hold_hit || (others == '0));
    // An owner that used up its burst yields to everyone else this cycle.
    cand             = ((state == LOCK) && hold_hit) ? others : bus.req;
    found            = 1'b0;
    win              = '0;
    idx              = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(rr_ptr) + k) % NREQ;
      if (!found && cand[idx]) begin
        found = 1'b1;
        win   = PW'(idx);
      end
    end
    win_bit      = '0;
    win_bit[win] = found;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      owner    <= '0;
      hold_cnt <= '0;
      gnt_q    <= '0;
      reg_en_q <= '0;
      reg_d_q  <= '0;
    end else if (keep) begin
      // Locked re-grant: pointer stays put so the burst does not steal others' turns.
      state    <= LOCK;
      gnt_q    <= owner_bit;
      reg_en_q <= decode(addr_a[owner]);
      reg_d_q  <= data_a[owner];
      if (!hold_hit) hold_cnt <= hold_cnt + HW'(1);
    end else if (found) begin
      gnt_q    <= win_bit;
      reg_en_q <= decode(addr_a[win]);
      reg_d_q  <= data_a[win];
      rr_ptr   <= (int'(win) == NREQ - 1) ? '0 : win + PW'(1);
      owner    <= win;
      if (bus.req_lock[win]) begin
        state    <= LOCK;
        hold_cnt <= HW'(1);
      end else begin
        state    <= GRANT;
        hold_cnt <= '0;
      end
    end else begin
      state    <= IDLE;
      hold_cnt <= '0;
      gnt_q    <= '0;
      reg_en_q <= '0;
      reg_d_q  <= '0;
    end
  end

  assign bus.gnt    = gnt_q;
  assign bus.reg_en = reg_en_q;
  assign bus.reg_d  = reg_d_q;
  assign bus.busy   = |gnt_q;
endmodule

// File: tb/tb_pipo_write_arbiter.sv
// Scoreboard bench: a reference model predicts each cycle's grant, queued at drive time, popped one cycle later.
module tb_pipo_write_arbiter;
  localparam int NREQ = 4, WIDTH = 4, NREG = 4, AW = 2, MAX_HOLD = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipo_write_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH), .NREG(NREG), .AW(AW)) bus ();
  pipo_write_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH), .NREG(3), .AW(AW)) bus3 ();

  assign bus3.req      = bus.req;
  assign bus3.req_lock = bus.req_lock;
  assign bus3.req_addr = bus.req_addr;
  assign bus3.req_data = bus.req_data;

  pipo_write_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .NREG(NREG), .AW(AW), .MAX_HOLD(MAX_HOLD))
    dut (.clk(clk), .rst(rst), .bus(bus.slave));
  pipo_write_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .NREG(3), .AW(AW), .MAX_HOLD(MAX_HOLD))
    dut3 (.clk(clk), .rst(rst), .bus(bus3.slave));

  typedef struct packed {
    logic [NREQ-1:0]  gnt;
    logic [NREG-1:0]  en;
    logic [WIDTH-1:0] d;
  } exp_t;

  typedef struct {
    logic [NREQ-1:0]  gnt;
    logic [NREG-1:0]  en;
    logic [WIDTH-1:0] d;
    logic             busy;
    logic [NREQ-1:0]  gnt3;
    logic [2:0]       en3;
    logic             busy3;
  } obs_t;

  exp_t sb[$];
  obs_t hist[$];
  int   n_cmp = 0;
  int   n_err = 0;

  int m_rr, m_owner, m_hold;
  bit m_lock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_rr = 0; m_owner = 0; m_hold = 0; m_lock = 0;
  endtask

  task automatic model(input logic [3:0] r, input logic [3:0] l, input logic [7:0] a,
                       input logic [15:0] d, output exp_t e);
    int         w;
    bit         keep;
    logic [3:0] others, cand;
    logic [1:0] ad;
    e = '0;
    w = -1;
    others = r;
    others[m_owner] = 1'b0;
    keep = m_lock && r[m_owner] && l[m_owner] && (m_hold < MAX_HOLD || others == 4'b0);
    if (keep) begin
      w = m_owner;
      if (m_hold < MAX_HOLD) m_hold++;
    end else begin
      cand = (m_lock && m_hold >= MAX_HOLD) ? others : r;
      for (int k = 0; k < NREQ; k++)
        if (w < 0 && cand[(m_rr + k) % NREQ]) w = (m_rr + k) % NREQ;
      if (w >= 0) begin
        m_rr    = (w + 1) % NREQ;
        m_lock  = l[w];
        m_owner = w;
        m_hold  = l[w] ? 1 : 0;
      end else begin
        m_lock = 0;
        m_hold = 0;
      end
    end
    if (w >= 0) begin
      ad    = a[w*AW +: AW];
      e.gnt = 4'(1 << w);
      e.en  = 4'(1 << ad);
      e.d   = d[w*WIDTH +: WIDTH];
    end
  endtask

  task automatic sample();
    exp_t e;
    obs_t o;
    @(negedge clk);
    if (sb.size() > 0) begin
      e       = sb.pop_front();
      o.gnt   = bus.gnt;   o.en  = bus.reg_en;  o.d = bus.reg_d; o.busy = bus.busy;
      o.gnt3  = bus3.gnt;  o.en3 = bus3.reg_en; o.busy3 = bus3.busy;
      hist.push_back(o);
      check("sb_gnt", bus.gnt, e.gnt);
      check("sb_reg_en", bus.reg_en, e.en);
      check("sb_reg_d", bus.reg_d, e.d);
      check("sb_busy", bus.busy, |e.gnt);
    end
  endtask

  task automatic drive(input logic [3:0] r, input logic [3:0] l, input logic [7:0] a,
                       input logic [15:0] d);
    exp_t e;
    bus.req = r; bus.req_lock = l; bus.req_addr = a; bus.req_data = d;
    model(r, l, a, d, e);
    sb.push_back(e);
  endtask

  task automatic step(input logic [3:0] r, input logic [3:0] l, input logic [7:0] a,
                      input logic [15:0] d);
    sample();
    drive(r, l, a, d);
  endtask

  task automatic reset_clear();
    rst = 1'b1;
    bus.req = '0; bus.req_lock = '0; bus.req_addr = '0; bus.req_data = '0;
    sb.delete();
    model_reset();
  endtask

  task automatic do_reset();
    reset_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    hist.delete();
  endtask

  localparam logic [7:0]  A_ID = 8'b11_10_01_00;
  localparam logic [15:0] D_ID = 16'hDCBA;

  initial begin
    logic [3:0] fair_g [5];
    logic [3:0] fair_d [5];
    logic [3:0] lock_g [8];
    logic [3:0] r, l;
    fair_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    fair_d = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hA};
    lock_g = '{4'b0010, 4'b0010, 4'b0010, 4'b0100, 4'b0010, 4'b0010, 4'b0010, 4'b0100};

    // reset held with every requester asking
    rst = 1'b1;
    bus.req = 4'b1111; bus.req_lock = '0; bus.req_addr = A_ID; bus.req_data = D_ID;
    model_reset();
    #12;
    check("rst_gnt", bus.gnt, 0);
    check("rst_reg_en", bus.reg_en, 0);
    check("rst_reg_d", bus.reg_d, 0);
    check("rst_busy", bus.busy, 0);
    @(negedge clk);
    rst = 1'b0;
    drive(4'b1111, 4'b0, A_ID, D_ID);
    step(4'b0, 4'b0, 8'h0, 16'h0);
    check("post_rst_first", hist[0].gnt, 4'b0001);

    // single write
    do_reset();
    step(4'b0001, 4'b0, 8'h02, 16'h000A);
    step(4'b0, 4'b0, 8'h0, 16'h0);
    step(4'b0, 4'b0, 8'h0, 16'h0);
    check("single_gnt", hist[0].gnt, 4'b0001);
    check("single_en", hist[0].en, 4'b0100);
    check("single_d", hist[0].d, 4'hA);
    check("single_busy", hist[0].busy, 1);
    check("single_after_gnt", hist[1].gnt, 0);
    check("single_after_busy", hist[1].busy, 0);

    // fairness
    do_reset();
    repeat (5) step(4'b1111, 4'b0, A_ID, D_ID);
    step(4'b0, 4'b0, 8'h0, 16'h0);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("fair_gnt%0d", i), hist[i].gnt, fair_g[i]);
      check($sformatf("fair_d%0d", i), hist[i].d, fair_d[i]);
    end

    // lock limit, then lone locked owner keeps the bank
    do_reset();
    repeat (8) step(4'b0110, 4'b0010, A_ID, D_ID);
    repeat (5) step(4'b0010, 4'b0010, A_ID, D_ID);
    step(4'b0, 4'b0, 8'h0, 16'h0);
    for (int i = 0; i < 8; i++) check($sformatf("lock_gnt%0d", i), hist[i].gnt, lock_g[i]);
    for (int i = 8; i < 13; i++) check($sformatf("lock_solo%0d", i), hist[i].gnt, 4'b0010);

    // out-of-range address on the 3-register instance
    do_reset();
    step(4'b0100, 4'b0, 8'h30, 16'h0500);
    step(4'b0, 4'b0, 8'h0, 16'h0);
    check("badaddr_gnt", hist[0].gnt3, 4'b0100);
    check("badaddr_en", hist[0].en3, 3'b000);
    check("badaddr_busy", hist[0].busy3, 1);
    check("badaddr_main_en", hist[0].en, 4'b1000);

    // reset during the second locked grant
    do_reset();
    step(4'b0110, 4'b0010, A_ID, D_ID);
    step(4'b0110, 4'b0010, A_ID, D_ID);
    sample();
    check("midlock_second", hist[1].gnt, 4'b0010);
    #2 rst = 1'b1;
    #1;
    check("midlock_rst_gnt", bus.gnt, 0);
    check("midlock_rst_en", bus.reg_en, 0);
    check("midlock_rst_d", bus.reg_d, 0);
    check("midlock_rst_busy", bus.busy, 0);
    do_reset();
    step(4'b1111, 4'b0, A_ID, D_ID);
    repeat (5) step(4'b0110, 4'b0010, A_ID, D_ID);
    step(4'b0, 4'b0, 8'h0, 16'h0);
    check("midlock_restart", hist[0].gnt, 4'b0001);
    for (int i = 1; i < 4; i++) check($sformatf("midlock_hold%0d", i), hist[i].gnt, 4'b0010);
    check("midlock_release", hist[4].gnt, 4'b0100);

    // random traffic against the model
    do_reset();
    for (int i = 0; i < 400; i++) begin
      r = 4'($urandom);
      l = ($urandom_range(0, 2) == 0) ? 4'($urandom) & r : 4'b0;
      step(r, l, 8'($urandom), 16'($urandom));
    end
    step(4'b0, 4'b0, 8'h0, 16'h0);
    sample();
    check("drain", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
